// File: rtl/mux4_pkg.sv
// mux4_pkg: shared constants and the round-robin grant function used by the
// four-channel multiplexer (mux4_rr) and its arbiter (rr_arb4).
//   N_CH    number of input channels
//   SEL_W   width of a channel index / tag
//   rr_next one-hot grant for the first requester after 'last' (cyclic)
package mux4_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  // Search order is last+1, last+2, last+3, last (mod N_CH); the first
  // requesting channel in that order wins. No request gives an all-zero grant.
  function automatic logic [N_CH-1:0] rr_next(input logic [N_CH-1:0]  req,
                                              input logic [SEL_W-1:0] last);
    logic [N_CH-1:0]  gnt;
    logic [SEL_W-1:0] idx;
    logic             found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx = SEL_W'(32'(last) + k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: purely combinational four-way round-robin arbiter.
//   req     [3:0] request per channel
//   last    [1:0] index of the most recently granted channel
//   gnt     [3:0] one-hot grant (zero when no request)
//   gnt_idx [1:0] binary index of the granted channel (0 when no request)
//   any           at least one request present
module rr_arb4
  import mux4_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [N_CH-1:0] w_gnt;

  assign w_gnt = rr_next(req, last);
  assign gnt   = w_gnt;
  assign any   = |req;

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_gnt[i]) gnt_idx = SEL_W'(i);
    end
  end

endmodule

// File: rtl/mux4_rr.sv
// mux4_rr: four-channel to one-channel multiplexer with round-robin
// arbitration, valid/ready handshakes on every port and a single registered
// output stage. Each output word carries its source channel in out_sel.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   [3:0]          per-channel word present
//   in_data    [4*DATA_W-1:0] channel i word at [i*DATA_W +: DATA_W]
//   in_ready   [3:0]          per-channel accept (at most one bit high)
//   out_valid                 output register holds a word
//   out_data   [DATA_W-1:0]   forwarded word
//   out_sel    [1:0]          source channel of out_data
//   out_ready                 downstream accepts out_data
module mux4_rr
  import mux4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  logic [SEL_W-1:0]  r_last;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_sel;

  logic [N_CH-1:0]   w_gnt;
  logic [SEL_W-1:0]  w_gnt_idx;
  logic              w_any;
  logic              w_can_load;
  logic              w_load;
  logic [DATA_W-1:0] w_words [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_words
    assign w_words[g] = in_data[g*DATA_W +: DATA_W];
  end

  rr_arb4 u_arb (
    .req     (in_valid),
    .last    (r_last),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // The slot is free when empty or when the held word leaves this cycle.
  assign w_can_load = ~r_out_valid | out_ready;
  // Reset wins over any transfer, so no channel is told it was accepted.
  assign in_ready   = w_gnt & {N_CH{w_can_load & ~rst}};
  assign w_load     = w_any & w_can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_last      <= SEL_W'(N_CH - 1);
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_words[w_gnt_idx];
      r_out_sel   <= w_gnt_idx;
      r_last      <= w_gnt_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux4_rr.sv
// tb_mux4_rr: directed, table-driven bench for mux4_rr. Each step drives
// inputs on the falling edge, checks in_ready before the rising edge and the
// registered outputs just after it.
module tb_mux4_rr;

  localparam int DATA_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mux4_rr #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_os;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D_BASE = 32'h1312_1110;

  task automatic add(input logic r, input logic [3:0] iv, input logic [31:0] d,
                     input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                     input logic [7:0] e_od, input logic [1:0] e_os);
    vec_t v;
    v.rst = r; v.iv = iv; v.data = d; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_os = e_os;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    in_valid  = v.iv;
    in_data   = v.data;
    out_ready = v.ordy;
    #1;
    check("in_ready", idx, 32'(in_ready), 32'(v.e_rdy));
    @(posedge clk);
    #1;
    check("out_valid", idx, 32'(out_valid), 32'(v.e_ov));
    check("out_data",  idx, 32'(out_data),  32'(v.e_od));
    check("out_sel",   idx, 32'(out_sel),   32'(v.e_os));
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Reset for two cycles with every channel requesting.
    add(1, 4'hF, D_BASE, 1, 4'b0000, 0, 8'h00, 2'd0);
    add(1, 4'hF, D_BASE, 1, 4'b0000, 0, 8'h00, 2'd0);
    // Round-robin over eight cycles starting at channel 0.
    add(0, 4'hF, D_BASE, 1, 4'b0001, 1, 8'h10, 2'd0);
    add(0, 4'hF, D_BASE, 1, 4'b0010, 1, 8'h11, 2'd1);
    add(0, 4'hF, D_BASE, 1, 4'b0100, 1, 8'h12, 2'd2);
    add(0, 4'hF, D_BASE, 1, 4'b1000, 1, 8'h13, 2'd3);
    add(0, 4'hF, D_BASE, 1, 4'b0001, 1, 8'h10, 2'd0);
    add(0, 4'hF, D_BASE, 1, 4'b0010, 1, 8'h11, 2'd1);
    add(0, 4'hF, D_BASE, 1, 4'b0100, 1, 8'h12, 2'd2);
    add(0, 4'hF, D_BASE, 1, 4'b1000, 1, 8'h13, 2'd3);
    // Single channel 2 with A5, then it drops: drain keeps data/sel.
    add(0, 4'b0100, 32'h13A5_1110, 1, 4'b0100, 1, 8'hA5, 2'd2);
    add(0, 4'b0000, D_BASE,        1, 4'b0000, 0, 8'hA5, 2'd2);
    // Channel 1 loads 3C into an empty slot while downstream stalls.
    add(0, 4'b0010, 32'h1312_3C10, 0, 4'b0010, 1, 8'h3C, 2'd1);
    // Five stall cycles with ch0 and ch3 requesting.
    for (int i = 0; i < 5; i++)
      add(0, 4'b1001, D_BASE, 0, 4'b0000, 1, 8'h3C, 2'd1);
    // Release: after last=1 the search goes 2,3 so ch3 precedes ch0.
    add(0, 4'b1001, D_BASE, 1, 4'b1000, 1, 8'h13, 2'd3);
    // Simultaneous drain and load from ch0, no bubble.
    add(0, 4'b0001, 32'h1312_115A, 1, 4'b0001, 1, 8'h5A, 2'd0);
    // Stall with no requests: word held.
    add(0, 4'b0000, D_BASE, 0, 4'b0000, 1, 8'h5A, 2'd0);

    foreach (vecs[i]) step(i, vecs[i]);

    // Reset while a word is stalled in the output register: the word is lost.
    v.rst = 1; v.iv = 4'hF; v.data = D_BASE; v.ordy = 0;
    v.e_rdy = 4'b0000; v.e_ov = 0; v.e_od = 8'h00; v.e_os = 2'd0;
    step(100, v);
    // Pointer restored: channel 0 wins first, even with downstream stalled.
    v.rst = 0; v.e_rdy = 4'b0001; v.e_ov = 1; v.e_od = 8'h10; v.e_os = 2'd0;
    step(101, v);
    // Stalled full register blocks every channel.
    v.e_rdy = 4'b0000;
    step(102, v);
    // Release: channel 1 follows.
    v.ordy = 1; v.e_rdy = 4'b0010; v.e_od = 8'h11; v.e_os = 2'd1;
    step(103, v);
    // Requester dropping before its turn: only ch0 left, wraps past 2,3.
    v.iv = 4'b0001; v.e_rdy = 4'b0001; v.e_od = 8'h10; v.e_os = 2'd0;
    step(104, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
